// File: rtl/dcache_tag_assoc.sv
// 2-way set-associative data-cache tag array with a lookup / write-back / refill controller.
// Define DCACHE_WRITEBACK_EN for a write-back policy; left undefined the cache is write-through.
module dcache_tag_assoc #(
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [31:0]               req_addr,
  input  logic                      req_wr,
  output logic                      req_ready,
  output logic                      resp_valid,
  output logic                      resp_way,
  output logic [(2**OFFSET_W)-1:0]  select_offset,
  output logic                      wb_req,
  output logic [31:0]               wb_addr,
  input  logic                      wb_done,
  output logic                      refill_req,
  output logic [31:0]               refill_addr,
  input  logic                      refill_done
);

  localparam int TAG_W = 32 - INDEX_W - OFFSET_W - 2;
  localparam int SETS  = 2**INDEX_W;
  localparam int SEL_W = 2**OFFSET_W;

`ifdef DCACHE_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_WB     = 2'd2;
  localparam logic [1:0] S_REFILL = 2'd3;

  logic [1:0]       state;
  logic [31:2]      addr_q;
  logic             wr_q;
  logic             victim_q;
  logic [SETS-1:0]  valid [2];
  logic [SETS-1:0]  dirty [2];
  logic [SETS-1:0]  lru;
  logic [TAG_W-1:0] tag_mem [2][SETS];

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                hit0, hit1, hit, hit_way;
  logic                miss_victim, victim_dirty;
  logic                unused_addr_lsb;

  assign req_tag = addr_q[31 -: TAG_W];
  assign req_idx = addr_q[OFFSET_W+2 +: INDEX_W];
  assign req_off = addr_q[2 +: OFFSET_W];
  assign unused_addr_lsb = ^req_addr[1:0];

  assign hit0    = valid[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
  assign hit1    = valid[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;

  // Fill empty ways first (way0 before way1), then evict the least recently used.
  always_comb begin
    miss_victim = lru[req_idx];
    if (!valid[0][req_idx])
      miss_victim = 1'b0;
    else if (!valid[1][req_idx])
      miss_victim = 1'b1;
  end

  assign victim_dirty = valid[miss_victim][req_idx] && dirty[miss_victim][req_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      victim_q <= 1'b0;
      valid[0] <= '0;
      valid[1] <= '0;
      dirty[0] <= '0;
      dirty[1] <= '0;
      lru      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr[31:2];
            wr_q   <= req_wr;
            state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            lru[req_idx] <= ~hit_way;
            if (WB_EN && wr_q)
              dirty[hit_way][req_idx] <= 1'b1;
            state <= S_IDLE;
          end else begin
            victim_q <= miss_victim;
            state    <= (WB_EN && victim_dirty) ? S_WB : S_REFILL;
          end
        end
        S_WB: begin
          if (wb_done)
            state <= S_REFILL;
        end
        S_REFILL: begin
          if (refill_done) begin
            valid[victim_q][req_idx] <= 1'b1;
            dirty[victim_q][req_idx] <= 1'b0;
            state <= S_LOOKUP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tags are not reset; a line only becomes visible once its valid bit is set.
  always_ff @(posedge clk) begin
    if (state == S_REFILL && refill_done)
      tag_mem[victim_q][req_idx] <= req_tag;
  end

  assign req_ready     = (state == S_IDLE) && !rst;
  assign resp_valid    = (state == S_LOOKUP) && hit;
  assign resp_way      = hit_way;
  assign select_offset = SEL_W'(1) << req_off;
  assign wb_req        = WB_EN && (state == S_WB);
  assign wb_addr       = WB_EN ? {tag_mem[victim_q][req_idx], req_idx, {(OFFSET_W+2){1'b0}}} : 32'd0;
  assign refill_req    = (state == S_REFILL);
  assign refill_addr   = {req_tag, req_idx, {(OFFSET_W+2){1'b0}}};

endmodule

// File: tb/tb_dcache_tag_assoc.sv
// Self-checking bench for dcache_tag_assoc: directed vector table, reset corner cases and
// randomized traffic against a transaction-level cache model.
module tb_dcache_tag_assoc;

`ifdef DCACHE_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_wr;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_way;
  logic [15:0] select_offset;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic        wb_done;
  logic        refill_req;
  logic [31:0] refill_addr;
  logic        refill_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  dcache_tag_assoc dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_wr(req_wr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_way(resp_way), .select_offset(select_offset),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_done(wb_done),
    .refill_req(refill_req), .refill_addr(refill_addr), .refill_done(refill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache model: per set, the resident tag of each way plus the most recently used way.
  bit          mvalid [2][256];
  bit          mdirty [2][256];
  int unsigned mtag   [2][256];
  bit          mmru   [256];

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic        hit;
    logic        way;
    logic        wb;
    logic [31:0] wb_addr;
    logic [31:0] rf_addr;
    int          wb_dly;
    int          rf_dly;
  } vec_t;

  vec_t vecs [7];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 256; s++) begin
      mvalid[0][s] = 1'b0;
      mvalid[1][s] = 1'b0;
      mdirty[0][s] = 1'b0;
      mdirty[1][s] = 1'b0;
      mmru[s]      = 1'b0;
    end
  endtask

  task automatic model_step(input logic [31:0] addr, input logic wr, output logic hit,
                            output logic way, output logic wb, output logic [31:0] wb_a,
                            output logic [31:0] rf_a);
    int unsigned idx;
    int unsigned tag;
    idx  = (addr >> 6) % 256;
    tag  = addr >> 14;
    hit  = 1'b0;
    way  = 1'b0;
    wb   = 1'b0;
    wb_a = 32'd0;
    rf_a = (tag << 14) | (idx << 6);
    for (int w = 0; w < 2; w++)
      if (mvalid[w][idx] && mtag[w][idx] == tag) begin
        hit = 1'b1;
        way = w[0];
      end
    if (!hit) begin
      if (!mvalid[0][idx])      way = 1'b0;
      else if (!mvalid[1][idx]) way = 1'b1;
      else                      way = !mmru[idx];
      if (WB_EN && mvalid[way][idx] && mdirty[way][idx]) begin
        wb   = 1'b1;
        wb_a = (mtag[way][idx] << 14) | (idx << 6);
      end
      mvalid[way][idx] = 1'b1;
      mtag[way][idx]   = tag;
      mdirty[way][idx] = 1'b0;
    end
    mmru[idx] = way;
    if (WB_EN && wr)
      mdirty[way][idx] = 1'b1;
  endtask

  // One complete transaction, from acceptance to the hitting LOOKUP cycle; ends at a LOOKUP negedge.
  task automatic apply_stimulus(input logic [31:0] addr, input logic wr, input logic exp_hit,
                                input logic exp_way, input logic exp_wb, input logic [31:0] exp_wb_addr,
                                input logic [31:0] exp_rf_addr, input int wb_dly, input int rf_dly,
                                input logic stray);
    logic [31:0] exp_sel;
    exp_sel = 32'd1 << ((addr >> 2) & 32'hF);
    @(negedge clk);
    check_output("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_addr    = addr;
    req_wr      = wr;
    wb_done     = stray & $urandom_range(0, 1);
    refill_done = stray & $urandom_range(0, 1);
    @(negedge clk);
    req_valid   = 1'b0;
    req_addr    = $urandom;
    req_wr      = $urandom_range(0, 1);
    wb_done     = stray & $urandom_range(0, 1);
    refill_done = stray & $urandom_range(0, 1);
    check_output("lookup_resp_valid", {31'd0, resp_valid}, {31'd0, exp_hit});
    check_output("lookup_ready", {31'd0, req_ready}, 32'd0);
    check_output("select_offset", {16'd0, select_offset}, exp_sel);
    if (exp_hit)
      check_output("hit_way", {31'd0, resp_way}, {31'd0, exp_way});
    else begin
      if (exp_wb) begin
        wb_done     = 1'b0;
        refill_done = 1'b0;
        @(negedge clk);
        check_output("wb_req_high", {31'd0, wb_req}, 32'd1);
        check_output("wb_addr", wb_addr, exp_wb_addr);
        check_output("refill_in_wb", {31'd0, refill_req}, 32'd0);
        for (int d = 0; d < wb_dly; d++) begin
          @(negedge clk);
          check_output("wb_req_held", {31'd0, wb_req}, 32'd1);
        end
        wb_done = 1'b1;
        @(negedge clk);
        wb_done = 1'b0;
      end else begin
        wb_done     = 1'b0;
        refill_done = 1'b0;
        @(negedge clk);
      end
      check_output("refill_req_high", {31'd0, refill_req}, 32'd1);
      check_output("refill_addr", refill_addr, exp_rf_addr);
      check_output("wb_req_low", {31'd0, wb_req}, 32'd0);
      check_output("select_offset_held", {16'd0, select_offset}, exp_sel);
      for (int d = 0; d < rf_dly; d++) begin
        @(negedge clk);
        check_output("refill_req_held", {31'd0, refill_req}, 32'd1);
      end
      refill_done = 1'b1;
      @(negedge clk);
      refill_done = 1'b0;
      check_output("post_fill_resp_valid", {31'd0, resp_valid}, 32'd1);
      check_output("post_fill_way", {31'd0, resp_way}, {31'd0, exp_way});
    end
  endtask

  task automatic run_access(input logic [31:0] addr, input logic wr, input int wb_dly,
                            input int rf_dly, input logic stray);
    logic        hit, way, wb;
    logic [31:0] wb_a, rf_a;
    model_step(addr, wr, hit, way, wb, wb_a, rf_a);
    apply_stimulus(addr, wr, hit, way, wb, wb_a, rf_a, wb_dly, rf_dly, stray);
  endtask

  initial begin
    logic        d_hit, d_way, d_wb;
    logic [31:0] d_wb_a, d_rf_a;
    logic [31:0] raddr;
    int unsigned rtags [4];
    int unsigned ridx  [2];

    vecs[0] = '{32'h0000_1040, 1'b0, 1'b0, 1'b0, 1'b0,  32'h0, 32'h0000_1040, 0, 1};
    vecs[1] = '{32'h0000_5040, 1'b0, 1'b0, 1'b1, 1'b0,  32'h0, 32'h0000_5040, 0, 0};
    vecs[2] = '{32'h0000_1044, 1'b1, 1'b1, 1'b0, 1'b0,  32'h0, 32'h0,         0, 0};
    vecs[3] = '{32'h0000_5040, 1'b0, 1'b1, 1'b1, 1'b0,  32'h0, 32'h0,         0, 0};
    vecs[4] = '{32'h0000_9040, 1'b0, 1'b0, 1'b0, WB_EN, 32'h0000_1040, 32'h0000_9040, 0, 0};
    vecs[5] = '{32'h0000_5048, 1'b0, 1'b1, 1'b1, 1'b0,  32'h0, 32'h0,         0, 0};
    vecs[6] = '{32'h0000_1040, 1'b0, 1'b0, 1'b0, 1'b0,  32'h0, 32'h0000_1040, 0, 2};

    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = 32'd0;
    req_wr = 1'b0;
    wb_done = 1'b0;
    refill_done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_output("reset_ready", {31'd0, req_ready}, 32'd0);
    check_output("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_output("reset_wb_req", {31'd0, wb_req}, 32'd0);
    check_output("reset_refill_req", {31'd0, refill_req}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      model_step(vecs[i].addr, vecs[i].wr, d_hit, d_way, d_wb, d_wb_a, d_rf_a);
      apply_stimulus(vecs[i].addr, vecs[i].wr, vecs[i].hit, vecs[i].way, vecs[i].wb,
                     vecs[i].wb_addr, vecs[i].rf_addr, vecs[i].wb_dly, vecs[i].rf_dly, 1'b0);
    end

    rtags[0] = 0; rtags[1] = 1; rtags[2] = 2; rtags[3] = 3;
    ridx[0] = 32'h41; ridx[1] = 32'h07;
    for (int n = 0; n < 80; n++) begin
      raddr = (rtags[$urandom_range(0, 3)] << 14) | (ridx[$urandom_range(0, 1)] << 6) |
              ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      run_access(raddr, $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
    end

    // Reset while a refill is outstanding: outputs drop at once and the line never lands.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'hA000_0100;
    req_wr    = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check_output("abort_lookup_miss", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check_output("abort_refill_req", {31'd0, refill_req}, 32'd1);
    check_output("abort_refill_addr", refill_addr, 32'hA000_0100);
    #2 rst = 1'b1;
    #1;
    check_output("abort_refill_drop", {31'd0, refill_req}, 32'd0);
    check_output("abort_ready_low", {31'd0, req_ready}, 32'd0);
    check_output("abort_resp_low", {31'd0, resp_valid}, 32'd0);
    check_output("abort_wb_low", {31'd0, wb_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_access(32'hA000_0100, 1'b0, 0, 1, 1'b0);
    run_access(32'h0000_1040, 1'b1, 0, 0, 1'b0);
    run_access(32'h0000_1040, 1'b0, 0, 0, 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
